serial_tx: RTL
==============

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter CLK_FREQ, 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, 115200, line bit rate in bit/s.
REQ-003 Parameter PARITY, 1, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, 1, number of stop bits, 1 or 2.
REQ-005 Parameter FLOW_CONTROL, 0, 0 ignores cts; 1 gates frame start on cts.
REQ-006 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-007 Port rst  input  1  reset, asynchronous, active-high.
REQ-008 Port tx_data  input  8  byte to transmit, sampled on accept.
REQ-009 Port tx_valid  input  1  byte request from producer.
REQ-010 Port tx_ready  output  1  block can accept a byte this cycle.
REQ-011 Port cts  input  1  peer clear-to-send, active-high, used only when FLOW_CONTROL=1.
REQ-012 Port tx  output  1  serial line, idle high.
REQ-013 Port busy  output  1  high while a frame is on the line.

Function
REQ-014 Bit period DIV = round(CLK_FREQ/BAUD_RATE) clocks (434 at defaults); the counter width is derived from DIV.
REQ-015 Accept occurs on a cycle with tx_valid=1 and tx_ready=1; tx_data is latched into an internal shift register on that edge.
REQ-016 tx_ready is 1 only in IDLE and, when FLOW_CONTROL=1, only while cts=1.
REQ-017 The FSM has states IDLE, START, DATA, PARITY and STOP, with these transitions:
- IDLE->START on accept;
- START->DATA after DIV clocks;
- DATA->PARITY (or ->STOP if PARITY=0) after 8*DIV clocks;
- PARITY->STOP after DIV clocks;
- STOP->IDLE after STOP_BITS*DIV clocks.
REQ-018 tx levels by state: 1 in IDLE, 0 in START, data bits LSB first in DATA, the parity bit in PARITY, 1 in STOP.
REQ-019 The parity bit is XOR of the 8 data bits for even parity and its inverse for odd parity.
REQ-020 tx falls exactly one clock after the accepting edge; every bit lasts exactly DIV clocks, with no drift across the frame.
REQ-021 busy is 1 in all states except IDLE, and tx_ready = !busy gated by cts.
REQ-022 Back-to-back frames: a byte accepted on the first IDLE cycle after STOP starts its start bit on the next cycle, with no extra idle bit.
REQ-023 tx_valid while tx_ready=0 is ignored and nothing is queued; tx_data changes after accept do not affect the frame in flight.
REQ-024 A cts deassert mid-frame does not abort or stretch the current frame; it only blocks the next accept.
REQ-025 tx is driven from a register (glitch-free).

Reset
REQ-026 While rst=1: tx=1, tx_ready=0, busy=0, FSM=IDLE, counters and shift register zeroed, effective asynchronously.
REQ-027 Reset asserted mid-frame returns tx to 1 immediately and drops the partial frame.
REQ-028 tx_ready rises on the first clock edge after rst deasserts, subject to cts when FLOW_CONTROL=1.

Structure
REQ-029 A shared package serial_pkg holds the parity mode constants (NONE/EVEN/ODD), the FSM state encoding and a divider/width calculation function, so that the future serial_rx reuses them.
REQ-030 The block contains one sub-module, baud_tick_gen, which generates a one-clock tick every DIV clocks and is restarted on accept.

Verification
REQ-031 Accept 0x55 at defaults -> tx sequence 0, 1,0,1,0,1,0,1,0, parity 0, stop 1; each bit 434 clocks; frame 4774 clocks; tx_ready back to 1 at clock 4775.
REQ-032 Accept 0x01 with PARITY=1 -> parity bit 1; same byte with PARITY=2 -> parity bit 0; with PARITY=0 -> frame of 10 bits (4340 clocks).
REQ-033 tx_valid held high with 0xA5 then 0x3C -> second start bit begins on the clock right after the first stop bit ends; both bytes decoded correctly by a bench-side reference receiver.
REQ-034 FLOW_CONTROL=1, cts=0, tx_valid=1 for 2000 clocks -> tx stays 1 and tx_ready stays 0; after cts rises, accept occurs on that cycle and the frame starts one clock later; cts dropped mid-frame -> frame completes unchanged.
REQ-035 rst pulsed during DATA bit 3 -> tx=1 within the same cycle, busy=0, and the next accepted byte is transmitted as a full, correct frame.

Source files
------------

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial transmitter and the future serial receiver:
//   - parity mode constants (PARITY_NONE / PARITY_EVEN / PARITY_ODD)
//   - frame FSM state encoding
//   - bit-period divider and counter-width helper functions
// No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } serial_state_t;

    // Clocks per bit, rounded to nearest. The arithmetic is widened so that
    // large clock frequencies cannot overflow the intermediate sum.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return int'((longint'(clk_freq) + longint'(baud_rate / 2)) / longint'(baud_rate));
    endfunction

    // Width of a counter that must hold 0 .. value-1 (never narrower than 1).
    function automatic int calc_width(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Produces a one-clock tick every DIV clocks while enabled. The count restarts
// from zero on 'restart', so the first tick after a restart arrives exactly DIV
// clocks later and the phase is locked to the accepting edge.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   restart in  clear the count (frame accept)
//   enable  in  count while high
//   tick    out high for one clock on the last clock of each bit period
// -----------------------------------------------------------------------------
module baud_tick_gen
    import serial_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = calc_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (restart) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    assign tick = enable && (count_reg == LAST);

endmodule

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// UART-style transmitter: start bit, 8 data bits LSB first, optional even/odd
// parity bit, 1 or 2 stop bits. Optional cts gating of the frame start.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   tx_data  in  [7:0] byte to send, captured on accept
//   tx_valid in  producer request
//   tx_ready out block can accept a byte this cycle
//   cts      in  peer clear-to-send (only used when FLOW_CONTROL=1)
//   tx       out serial line, idle high, registered
//   busy     out high while a frame is on the line
// -----------------------------------------------------------------------------
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int FLOW_CONTROL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       cts,
    output logic       tx,
    output logic       busy
);

    localparam int         DIV       = calc_div(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    serial_state_t state_reg, state_next;
    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bit_reg, bit_next;
    logic          parity_reg, parity_next;
    logic          tx_reg, tx_next;
    logic          ready_en_reg;
    logic          cts_ok;
    logic          accept;
    logic          tick;

    assign cts_ok   = (FLOW_CONTROL == 0) ? 1'b1 : cts;
    assign busy     = (state_reg != ST_IDLE);
    // ready_en_reg keeps tx_ready low until the first edge after reset release.
    assign tx_ready = ready_en_reg && !busy && cts_ok;
    assign accept   = tx_valid && tx_ready;
    assign tx       = tx_reg;

    baud_tick_gen #(
        .DIV(DIV)
    ) u_baud_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(accept),
        .enable (busy),
        .tick   (tick)
    );

    // State register (plus the datapath registers that move with it).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_reg      <= '0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            ready_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_reg      <= bit_next;
            parity_reg   <= parity_next;
            tx_reg       <= tx_next;
            ready_en_reg <= 1'b1;
        end
    end

    // Next-state logic. bit_reg counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        bit_next    = bit_reg;
        parity_next = parity_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next  = ST_START;
                    shift_next  = tx_data;
                    bit_next    = '0;
                    parity_next = (^tx_data) ^ (PARITY == PARITY_ODD);
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_reg == 3'd7) begin
                        state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        bit_next   = '0;
                    end else begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        bit_next   = bit_reg + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_next = ST_STOP;
                    bit_next   = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_reg == LAST_STOP) begin
                        state_next = ST_IDLE;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: the line level is computed for the state being entered so
    // that tx_reg changes on the same edge as the state and never glitches.
    always_comb begin
        tx_next = 1'b1;
        unique case (state_next)
            ST_IDLE:   tx_next = 1'b1;
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = parity_next;
            ST_STOP:   tx_next = 1'b1;
            default:   tx_next = 1'b1;
        endcase
    end

endmodule
